// File: rtl/sd_dsp_pkg.sv
// Shared DSP helpers for the sigma-delta decimation path.
// Contents:
//   sd_bit_t   - bitstream symbol; 0 stands for -1 and 1 stands for +1
//   clog2      - ceiling log2, usable in constant expressions
//   acc_w      - CIC accumulator width for a given order / decimation ratio
//   sat_shift  - arithmetic rescale followed by symmetric clamp to out_w bits
package sd_dsp_pkg;

    typedef enum logic {
        SD_BIT_NEG = 1'b0,
        SD_BIT_POS = 1'b1
    } sd_bit_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Growth of an N-stage CIC is N*log2(R) bits plus sign, plus one bit so
    // that +R^N itself is representable.
    function automatic int acc_w(input int order, input int decim);
        return order * clog2(decim) + 2;
    endfunction

    // A negative shift means the accumulator is narrower than the output word.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] y,
                                                     input int shift,
                                                     input int out_w);
        logic signed [63:0] q;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (shift >= 0) begin
            q = y >>> shift;
        end else begin
            q = y <<< (-shift);
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (q > hi) begin
            return hi;
        end else if (q < lo) begin
            return lo;
        end else begin
            return q;
        end
    endfunction

endpackage

// File: rtl/sd_cic_comb.sv
// One CIC comb section: o_out = i_in - d, and d <= i_in on strobe cycles.
// Ports:
//   clk, aresetn - clock and asynchronous active-low reset
//   i_clear      - synchronous clear of the delay register
//   i_stb        - load the delay register with the current input
//   i_in         - section input (previous comb or decimated sample)
//   o_out        - combinational difference, modulo 2^W
module sd_cic_comb #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         i_clear,
    input  logic         i_stb,
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_out
);

    logic [W-1:0] r_dly;

    assign o_out = i_in - r_dly;

    // Delay register holds the previous decimated input of this section.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_dly <= {W{1'b0}};
        end else if (i_clear) begin
            r_dly <= {W{1'b0}};
        end else if (i_stb) begin
            r_dly <= i_in;
        end else begin
            r_dly <= r_dly;
        end
    end

endmodule

// File: rtl/sd_cic_decimator.sv
// Sinc^ORDER CIC decimator: 1-bit sigma-delta stream in, signed PCM out.
// Ports:
//   clk       - single clock
//   aresetn   - asynchronous active-low reset
//   enable    - synchronous run control; low clears all state
//   bs_valid  - bitstream strobe (one accepted beat per high cycle)
//   bs_data   - bitstream bit, 1 -> +1, 0 -> -1
//   pcm_valid - one-cycle pulse per decimated sample, after warm-up
//   pcm_data  - signed PCM sample, held between pulses
// Timing: the beat that completes a frame is sampled at edge t; the sample
// register and strobe update there, the combs evaluate during t+1 and the
// output register shows the result in cycle t+2.
module sd_cic_decimator
    import sd_dsp_pkg::*;
#(
    parameter int ORDER = 3,
    parameter int DECIM = 256,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             enable,
    input  logic             bs_valid,
    input  logic             bs_data,
    output logic             pcm_valid,
    output logic [OUT_W-1:0] pcm_data
);

    localparam int LOG_R  = clog2(DECIM);
    localparam int ACC_W  = acc_w(ORDER, DECIM);
    localparam int SHIFT  = ORDER * LOG_R + 1 - OUT_W;
    localparam int WARM_W = clog2(ORDER + 1);

    sd_bit_t                 w_bit;
    logic [ACC_W-1:0]        w_x;
    logic [ACC_W-1:0]        w_integ_next [ORDER];
    logic [ACC_W-1:0]        r_integ [ORDER];
    logic [LOG_R-1:0]        r_phase;
    logic                    w_frame_end;
    logic [ACC_W-1:0]        r_samp;
    logic                    r_samp_stb;
    logic [ACC_W-1:0]        w_comb [ORDER+1];
    logic signed [ACC_W-1:0] w_y;
    logic [63:0]             w_y_ext;
    logic [OUT_W-1:0]        w_pcm_next;
    logic [WARM_W-1:0]       r_warm;
    logic                    r_pcm_valid;
    logic [OUT_W-1:0]        r_pcm_data;

    assign w_bit = sd_bit_t'(bs_data);

    // Map the bitstream symbol onto a two's-complement +1 / -1.
    always_comb begin
        w_x = {ACC_W{1'b1}};
        if (w_bit == SD_BIT_POS) begin
            w_x = {{(ACC_W-1){1'b0}}, 1'b1};
        end else begin
            w_x = {ACC_W{1'b1}};
        end
    end

    // Direct-form integrator chain: each stage adds the updated value of the
    // stage before it in the same beat. Wrap-around is intentional.
    always_comb begin
        for (int k = 0; k < ORDER; k++) begin
            w_integ_next[k] = {ACC_W{1'b0}};
        end
        w_integ_next[0] = r_integ[0] + w_x;
        for (int k = 1; k < ORDER; k++) begin
            w_integ_next[k] = r_integ[k] + w_integ_next[k-1];
        end
    end

    // DECIM is a power of two, so the frame ends when the phase is all ones.
    assign w_frame_end = bs_valid & (&r_phase);

    // Integrators, frame phase and decimated sample capture.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < ORDER; k++) begin
                r_integ[k] <= {ACC_W{1'b0}};
            end
            r_phase    <= {LOG_R{1'b0}};
            r_samp     <= {ACC_W{1'b0}};
            r_samp_stb <= 1'b0;
        end else if (!enable) begin
            for (int k = 0; k < ORDER; k++) begin
                r_integ[k] <= {ACC_W{1'b0}};
            end
            r_phase    <= {LOG_R{1'b0}};
            r_samp     <= {ACC_W{1'b0}};
            r_samp_stb <= 1'b0;
        end else begin
            if (bs_valid) begin
                for (int k = 0; k < ORDER; k++) begin
                    r_integ[k] <= w_integ_next[k];
                end
                r_phase <= r_phase + LOG_R'(1);
            end else begin
                for (int k = 0; k < ORDER; k++) begin
                    r_integ[k] <= r_integ[k];
                end
                r_phase <= r_phase;
            end
            if (w_frame_end) begin
                r_samp     <= w_integ_next[ORDER-1];
                r_samp_stb <= 1'b1;
            end else begin
                r_samp     <= r_samp;
                r_samp_stb <= 1'b0;
            end
        end
    end

    assign w_comb[0] = r_samp;

    genvar g;
    generate
        for (g = 0; g < ORDER; g++) begin : g_comb
            sd_cic_comb #(
                .W(ACC_W)
            ) u_comb (
                .clk    (clk),
                .aresetn(aresetn),
                .i_clear(~enable),
                .i_stb  (r_samp_stb),
                .i_in   (w_comb[g]),
                .o_out  (w_comb[g+1])
            );
        end
    endgenerate

    assign w_y        = w_comb[ORDER];
    assign w_y_ext    = {{(64-ACC_W){w_y[ACC_W-1]}}, w_y};
    assign w_pcm_next = OUT_W'(sat_shift($signed(w_y_ext), SHIFT, OUT_W));

    // Warm-up gate and output register; combs are only meaningful once every
    // delay has seen a real sample, so the first ORDER results are dropped.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_warm      <= {WARM_W{1'b0}};
            r_pcm_valid <= 1'b0;
            r_pcm_data  <= {OUT_W{1'b0}};
        end else if (!enable) begin
            r_warm      <= {WARM_W{1'b0}};
            r_pcm_valid <= 1'b0;
            r_pcm_data  <= {OUT_W{1'b0}};
        end else if (r_samp_stb) begin
            if (r_warm == WARM_W'(ORDER)) begin
                r_warm      <= r_warm;
                r_pcm_valid <= 1'b1;
                r_pcm_data  <= w_pcm_next;
            end else begin
                r_warm      <= r_warm + WARM_W'(1);
                r_pcm_valid <= 1'b0;
                r_pcm_data  <= r_pcm_data;
            end
        end else begin
            r_warm      <= r_warm;
            r_pcm_valid <= 1'b0;
            r_pcm_data  <= r_pcm_data;
        end
    end

    assign pcm_valid = r_pcm_valid;
    assign pcm_data  = r_pcm_data;

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Self-checking bench for sd_cic_decimator at default parameters.
// Reference: each decimated sample is the convolution of the accepted +/-1
// beats with the boxcar^ORDER impulse response, rescaled and clamped.
module tb_sd_cic_decimator;

    localparam int ORDER = 3;
    localparam int DECIM = 256;
    localparam int OUT_W = 16;
    localparam int LOG_R = $clog2(DECIM);
    localparam int SHIFT = ORDER * LOG_R + 1 - OUT_W;
    localparam int HLEN  = ORDER * (DECIM - 1) + 1;

    logic             clk = 1'b0;
    logic             aresetn = 1'b0;
    logic             enable = 1'b0;
    logic             bs_valid = 1'b0;
    logic             bs_data = 1'b0;
    logic             pcm_valid;
    logic [OUT_W-1:0] pcm_data;

    always #5 clk = ~clk;

    sd_cic_decimator #(
        .ORDER(ORDER),
        .DECIM(DECIM),
        .OUT_W(OUT_W)
    ) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .enable   (enable),
        .bs_valid (bs_valid),
        .bs_data  (bs_data),
        .pcm_valid(pcm_valid),
        .pcm_data (pcm_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    longint h [HLEN];
    int     hist [$];
    int     beats;
    int     frames;
    logic             exp_valid_d;
    logic [OUT_W-1:0] exp_data_d;
    logic [OUT_W-1:0] exp_data;
    int     cyc;
    int     last_beat_cyc;
    int     pulse_cnt;
    int     last_pulse_cyc;
    int     prev_pulse_cyc;
    int     last_lat;
    logic [OUT_W-1:0] last_pulse_data;

    typedef struct {
        logic [3:0] pat;
        int         stride;
        longint     exp_val;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic longint model_y();
        longint acc;
        int n;
        acc = 0;
        n = hist.size() - 1;
        for (int k = 0; k < HLEN; k++)
            if (n - k >= 0) acc += h[k] * longint'(hist[n-k]);
        return acc;
    endfunction

    function automatic logic [OUT_W-1:0] model_q(input longint y);
        longint q;
        longint hi;
        longint lo;
        q  = y >>> SHIFT;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -hi - 1;
        if (q > hi) q = hi;
        else if (q < lo) q = lo;
        return q[OUT_W-1:0];
    endfunction

    task automatic model_clear();
        hist.delete();
        beats       = 0;
        frames      = 0;
        exp_valid_d = 1'b0;
        exp_data    = '0;
    endtask

    // One clock: apply inputs, update the model, then compare after the edge.
    task automatic step(input logic v, input logic d, input logic en);
        logic             nv;
        logic [OUT_W-1:0] nd;
        logic             ev;
        nv = 1'b0;
        nd = '0;
        bs_valid = v;
        bs_data  = d;
        enable   = en;
        if (!en || !aresetn) begin
            model_clear();
        end else if (v) begin
            hist.push_back(d ? 1 : -1);
            if (hist.size() > HLEN) void'(hist.pop_front());
            beats++;
            if (beats % DECIM == 0) begin
                frames++;
                last_beat_cyc = cyc;
                if (frames > ORDER) begin
                    nv = 1'b1;
                    nd = model_q(model_y());
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        ev = exp_valid_d;
        if (ev) exp_data = exp_data_d;
        check("pcm_valid", longint'(pcm_valid), longint'(ev));
        check("pcm_data", longint'($signed(pcm_data)), longint'($signed(exp_data)));
        exp_valid_d = nv;
        exp_data_d  = nd;
        if (pcm_valid) begin
            pulse_cnt++;
            prev_pulse_cyc  = last_pulse_cyc;
            last_pulse_cyc  = cyc;
            last_pulse_data = pcm_data;
            last_lat        = cyc - last_beat_cyc;
        end
    endtask

    task automatic run_pattern(input logic [3:0] pat, input int nbeats, input int stride);
        for (int i = 0; i < nbeats; i++) begin
            step(1'b1, pat[i % 4], 1'b1);
            for (int s = 1; s < stride; s++) step(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic restart();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        pulse_cnt = 0;
        last_pulse_cyc = 0;
        prev_pulse_cyc = 0;
    endtask

    initial begin
        longint tmp [HLEN];
        longint s;

        // boxcar^ORDER impulse response
        for (int i = 0; i < HLEN; i++) h[i] = (i == 0) ? 1 : 0;
        for (int st = 0; st < ORDER; st++) begin
            for (int i = 0; i < HLEN; i++) begin
                s = 0;
                for (int j = 0; j < DECIM; j++) if (i - j >= 0) s += h[i-j];
                tmp[i] = s;
            end
            for (int i = 0; i < HLEN; i++) h[i] = tmp[i];
        end

        vecs[0] = '{pat: 4'b1111, stride: 1, exp_val:  32767};
        vecs[1] = '{pat: 4'b0000, stride: 1, exp_val: -32768};
        vecs[2] = '{pat: 4'b0101, stride: 1, exp_val:  0};
        vecs[3] = '{pat: 4'b0111, stride: 1, exp_val:  16384};
        vecs[4] = '{pat: 4'b0111, stride: 2, exp_val:  16384};

        cyc = 0;
        last_beat_cyc = 0;
        last_lat = 0;
        last_pulse_data = '0;
        model_clear();
        exp_data_d = '0;

        #1;
        check("reset_valid", longint'(pcm_valid), 0);
        check("reset_data", longint'($signed(pcm_data)), 0);
        @(negedge clk);
        aresetn = 1'b1;

        // Steady-state patterns from the table
        for (int v = 0; v < 5; v++) begin
            restart();
            run_pattern(vecs[v].pat, 6 * DECIM, vecs[v].stride);
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1);
            check($sformatf("vec%0d_pulses", v), pulse_cnt, 3);
            check($sformatf("vec%0d_value", v), longint'($signed(last_pulse_data)), vecs[v].exp_val);
            check($sformatf("vec%0d_spacing", v), last_pulse_cyc - prev_pulse_cyc, DECIM * vecs[v].stride);
            check($sformatf("vec%0d_latency", v), last_lat, 2);
        end

        // Asynchronous reset at phase 100 of frame 5
        restart();
        run_pattern(4'b0111, 4 * DECIM + 100, 1);
        check("arst_pre_data", longint'($signed(pcm_data)), 16384);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_imm_valid", longint'(pcm_valid), 0);
        check("arst_imm_data", longint'($signed(pcm_data)), 0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        aresetn = 1'b1;
        pulse_cnt = 0;
        run_pattern(4'b0111, 3 * DECIM, 1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("arst_warm_pulses", pulse_cnt, 0);
        run_pattern(4'b0111, DECIM, 1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("arst_first_pulse", pulse_cnt, 1);
        check("arst_first_value", longint'($signed(last_pulse_data)), 16384);

        // Enable drop at phase 100 of frame 5
        restart();
        run_pattern(4'b0111, 4 * DECIM + 100, 1);
        enable = 1'b0;
        #1;
        check("en_hold_before_edge", longint'($signed(pcm_data)), 16384);
        step(1'b1, 1'b1, 1'b0);
        check("en_cleared_data", longint'($signed(pcm_data)), 0);
        step(1'b1, 1'b0, 1'b0);
        pulse_cnt = 0;
        run_pattern(4'b0111, 3 * DECIM, 1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("en_warm_pulses", pulse_cnt, 0);
        run_pattern(4'b0111, DECIM, 1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("en_first_pulse", pulse_cnt, 1);
        check("en_first_value", longint'($signed(last_pulse_data)), 16384);

        // Random bits and gappy strobe against the model, with a mid-run enable drop
        restart();
        for (int i = 0; i < 6000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 65, (i < 2900 || i > 2903));
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("rand_saw_pulses", longint'(pulse_cnt > 2), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
